// File: rtl/mem_data_arbiter_pkg.sv
// Shared definitions for the mem_data arbiter: bus widths, lock limit
// default, requester identifiers and small helpers.
package mem_data_arbiter_pkg;

    // Address width of mem_data (word addressed).
    localparam int MEM_WIDTH  = 10;
    // Data word width of mem_data.
    localparam int DATA_WIDTH = 16;
    // Default bound on consecutive granted cycles while a requester holds the lock.
    localparam int LOCK_MAX_DEFAULT = 16;

    // Identifies one of the two requesters; also used to remember the last winner.
    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    // Request bundle from one requester, captured as a unit for routing.
    typedef struct packed {
        logic                  req;
        logic                  we;
        logic                  lock;
        logic [MEM_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // The requester that is not 's'; round-robin favours this one on a tie.
    function automatic side_e side_other(input side_e s);
        return (s == SIDE_A) ? SIDE_B : SIDE_A;
    endfunction

    // Width needed to count up to and including 'max_val'.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational two-way round-robin grant. A lone requester always wins;
// on a tie the requester that did not win last time is chosen.
import mem_data_arbiter_pkg::*;

module mem_arb_rr2 (
    input  logic  req_a_i,
    input  logic  req_b_i,
    input  side_e last_i,
    output logic  gnt_a_o,
    output logic  gnt_b_o
);

    side_e favoured;

    // Tie-break towards the side opposite the previous winner.
    always_comb begin
        favoured = side_other(last_i);
        gnt_a_o  = 1'b0;
        gnt_b_o  = 1'b0;
        if (req_a_i && req_b_i) begin
            gnt_a_o = (favoured == SIDE_A);
            gnt_b_o = (favoured == SIDE_B);
        end else begin
            gnt_a_o = req_a_i;
            gnt_b_o = req_b_i;
        end
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Shares the single-port mem_data between requester A (load/store unit)
// and requester B (I/O / DMA). Per-cycle round-robin, optional bus lock
// bounded to LOCK_MAX consecutive grants, and return of the 1-cycle read
// data to whichever side was granted the read.
import mem_data_arbiter_pkg::*;

module mem_data_arbiter #(
    // Maximum consecutive grants to a locked owner; must be at least 2.
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic                  a_lock_i,
    input  logic [MEM_WIDTH-1:0]  a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,

    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic                  b_lock_i,
    input  logic [MEM_WIDTH-1:0]  b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,

    output logic                  m_we_o,
    output logic [MEM_WIDTH-1:0]  m_addr_o,
    output logic [DATA_WIDTH-1:0] m_data_in_o,
    input  logic [DATA_WIDTH-1:0] m_data_out_i
);

    // Ownership states; legacy-style constants kept in this file.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam int               CNT_W   = cnt_width(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    side_e            last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             a_rvalid_q, b_rvalid_q;

    mem_req_t         req_a, req_b;
    logic             arb_gnt_a, arb_gnt_b;
    logic             gnt_a, gnt_b;

    assign req_a = '{req: a_req_i, we: a_we_i, lock: a_lock_i, addr: a_addr_i, wdata: a_wdata_i};
    assign req_b = '{req: b_req_i, we: b_we_i, lock: b_lock_i, addr: b_addr_i, wdata: b_wdata_i};

    mem_arb_rr2 u_rr2 (
        .req_a_i (req_a.req),
        .req_b_i (req_b.req),
        .last_i  (last_q),
        .gnt_a_o (arb_gnt_a),
        .gnt_b_o (arb_gnt_b)
    );

    // Ownership FSM: decides this cycle's grant and the next state/lock count.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_a      = arb_gnt_a;
                gnt_b      = arb_gnt_b;
                lock_cnt_d = '0;
                if (arb_gnt_a) begin
                    last_d = SIDE_A;
                    if (req_a.lock) begin
                        state_d    = ST_OWN_A;
                        lock_cnt_d = CNT_ONE;
                    end
                end else if (arb_gnt_b) begin
                    last_d = SIDE_B;
                    if (req_b.lock) begin
                        state_d    = ST_OWN_B;
                        lock_cnt_d = CNT_ONE;
                    end
                end
            end
            ST_OWN_A: begin
                // Expiry is checked first so a locked owner cannot exceed the bound.
                if (lock_cnt_q == CNT_MAX) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    last_d     = SIDE_A;
                end else if (req_a.req) begin
                    gnt_a = 1'b1;
                    if (req_a.lock) begin
                        lock_cnt_d = lock_cnt_q + CNT_ONE;
                    end else begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            ST_OWN_B: begin
                if (lock_cnt_q == CNT_MAX) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    last_d     = SIDE_B;
                end else if (req_b.req) begin
                    gnt_b = 1'b1;
                    if (req_b.lock) begin
                        lock_cnt_d = lock_cnt_q + CNT_ONE;
                    end else begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Grants are suppressed while reset is asserted, since the FSM sits in
    // IDLE during reset and would otherwise grant a waiting requester.
    assign a_gnt_o = gnt_a & rst_n;
    assign b_gnt_o = gnt_b & rst_n;

    // Memory port routing: winner's address/data, A's when nobody is granted.
    assign m_we_o      = (a_gnt_o & req_a.we) | (b_gnt_o & req_b.we);
    assign m_addr_o    = b_gnt_o ? req_b.addr  : req_a.addr;
    assign m_data_in_o = b_gnt_o ? req_b.wdata : req_a.wdata;

    // FSM, last-winner and lock counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= SIDE_B;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Read-data valid flags: one cycle after a read grant, matching mem_data latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_gnt_o & ~req_a.we;
            b_rvalid_q <= b_gnt_o & ~req_b.we;
        end
    end

    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rdata_o  = m_data_out_i;
    assign b_rdata_o  = m_data_out_i;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a behavioural single-port memory.
import mem_data_arbiter_pkg::*;

module tb_mem_data_arbiter;

    logic                  clk;
    logic                  rst_n;
    logic                  a_req, a_we, a_lock;
    logic [MEM_WIDTH-1:0]  a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt, a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  b_req, b_we, b_lock;
    logic [MEM_WIDTH-1:0]  b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt, b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  m_we;
    logic [MEM_WIDTH-1:0]  m_addr;
    logic [DATA_WIDTH-1:0] m_data_in;
    logic [DATA_WIDTH-1:0] m_data_out;

    logic                  load;
    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_WIDTH)-1];

    int total;
    int bad;

    mem_data_arbiter #(.LOCK_MAX(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req_i      (a_req),
        .a_we_i       (a_we),
        .a_lock_i     (a_lock),
        .a_addr_i     (a_addr),
        .a_wdata_i    (a_wdata),
        .a_gnt_o      (a_gnt),
        .a_rvalid_o   (a_rvalid),
        .a_rdata_o    (a_rdata),
        .b_req_i      (b_req),
        .b_we_i       (b_we),
        .b_lock_i     (b_lock),
        .b_addr_i     (b_addr),
        .b_wdata_i    (b_wdata),
        .b_gnt_o      (b_gnt),
        .b_rvalid_o   (b_rvalid),
        .b_rdata_o    (b_rdata),
        .m_we_o       (m_we),
        .m_addr_o     (m_addr),
        .m_data_in_o  (m_data_in),
        .m_data_out_i (m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory, 1-cycle read latency. Contents are
    // A000+addr, except mem[5] = 1234, loaded while 'load' is high.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < (1 << MEM_WIDTH); i++) begin
                mem[i] <= (i == 5) ? 16'h1234 : (16'hA000 + 16'(i));
            end
        end else begin
            if (m_we) mem[m_addr] <= m_data_in;
            m_data_out <= mem[m_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        load  = 1;
        rst_n = 0;
        idle_inputs();
        // Requests during reset must not leak through as grants or writes.
        a_req = 1; a_we = 1; b_req = 1;
        tick();
        tick();
        load = 0;
        check("rst a_gnt", a_gnt, 0);
        check("rst b_gnt", b_gnt, 0);
        check("rst m_we", m_we, 0);
        check("rst a_rvalid", a_rvalid, 0);
        check("rst b_rvalid", b_rvalid, 0);
        idle_inputs();
        rst_n = 1;
        tick();

        // 1: single read by A of addr 5.
        a_req = 1; a_addr = 10'd5;
        #1;
        check("t1 a_gnt", a_gnt, 1);
        check("t1 b_gnt", b_gnt, 0);
        check("t1 m_addr", m_addr, 5);
        check("t1 m_we", m_we, 0);
        tick();
        a_req = 0;
        #1;
        check("t1 a_rvalid", a_rvalid, 1);
        check("t1 a_rdata", a_rdata, 16'h1234);
        check("t1 b_rvalid", b_rvalid, 0);
        tick();

        // 2: continuous contention alternates A,B,A,B,A,B after reset.
        do_reset();
        a_req = 1; a_addr = 10'd1;
        b_req = 1; b_addr = 10'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t2 a_gnt[%0d]", i), a_gnt, (i % 2 == 0));
            check($sformatf("t2 b_gnt[%0d]", i), b_gnt, (i % 2 == 1));
            check($sformatf("t2 a_rvalid[%0d]", i), a_rvalid, (i % 2 == 1));
            check($sformatf("t2 b_rvalid[%0d]", i), b_rvalid, (i > 0 && i % 2 == 0));
            if (i % 2 == 1) check($sformatf("t2 a_rdata[%0d]", i), a_rdata, 16'hA001);
            if (i > 0 && i % 2 == 0) check($sformatf("t2 b_rdata[%0d]", i), b_rdata, 16'hA002);
            tick();
        end
        idle_inputs();
        #1;
        check("t2 b_rvalid end", b_rvalid, 1);
        check("t2 b_rdata end", b_rdata, 16'hA002);
        check("t2 a_rvalid end", a_rvalid, 0);
        tick();

        // 3: A writes BEEF to addr 3 while B reads addr 3; last winner was B.
        a_req = 1; a_we = 1; a_addr = 10'd3; a_wdata = 16'hBEEF;
        b_req = 1; b_addr = 10'd3;
        #1;
        check("t3 a_gnt", a_gnt, 1);
        check("t3 b_gnt", b_gnt, 0);
        check("t3 m_we", m_we, 1);
        check("t3 m_addr", m_addr, 3);
        check("t3 m_data_in", m_data_in, 16'hBEEF);
        tick();
        a_req = 0; a_we = 0;
        #1;
        check("t3 b_gnt", b_gnt, 1);
        check("t3 m_we rd", m_we, 0);
        check("t3 a_rvalid wr", a_rvalid, 0);
        tick();
        idle_inputs();
        #1;
        check("t3 b_rvalid", b_rvalid, 1);
        check("t3 b_rdata", b_rdata, 16'hBEEF);
        tick();

        // 4: B locked and requesting; A waits. B alone in cycle 0, A joins after.
        b_req = 1; b_lock = 1; b_addr = 10'd4;
        for (int i = 0; i < 18; i++) begin
            if (i == 1) begin
                a_req = 1; a_addr = 10'd6;
            end
            #1;
            check($sformatf("t4 b_gnt[%0d]", i), b_gnt, (i < 16));
            check($sformatf("t4 a_gnt[%0d]", i), a_gnt, (i == 17));
            tick();
        end
        idle_inputs();
        tick();

        // 5: B wins the tie (last=A), drops lock on its 3rd access, then A.
        a_req = 1; a_addr = 10'd6;
        b_req = 1; b_lock = 1; b_addr = 10'd7;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) b_lock = 0;
            #1;
            check($sformatf("t5 b_gnt[%0d]", i), b_gnt, (i < 3));
            check($sformatf("t5 a_gnt[%0d]", i), a_gnt, (i == 3));
            if (i > 0 && i < 4) begin
                check($sformatf("t5 b_rvalid[%0d]", i), b_rvalid, 1);
                check($sformatf("t5 b_rdata[%0d]", i), b_rdata, 16'hA007);
            end
            tick();
            if (i == 2) b_req = 0;
        end
        idle_inputs();
        tick();

        // 6: reset pulsed during a read grant drops the pending rvalid.
        a_req = 1; a_addr = 10'd5;
        #1;
        check("t6 a_gnt pre", a_gnt, 1);
        rst_n = 0;
        #1;
        check("t6 a_gnt in rst", a_gnt, 0);
        check("t6 m_we in rst", m_we, 0);
        tick();
        check("t6 a_rvalid rst", a_rvalid, 0);
        rst_n = 1;
        a_req = 0;
        tick();
        check("t6 a_rvalid post", a_rvalid, 0);
        a_req = 1; a_addr = 10'd5;
        b_req = 1; b_addr = 10'd2;
        #1;
        check("t6 tie a_gnt", a_gnt, 1);
        check("t6 tie b_gnt", b_gnt, 0);
        tick();
        idle_inputs();
        #1;
        check("t6 a_rvalid", a_rvalid, 1);
        check("t6 a_rdata", a_rdata, 16'h1234);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
